// File: rtl/icap_pkg.sv
// Shared constants, state encoding and helpers for the ICAP warm-reboot sequencer.
// The constants are the Virtex-6 IPROG command words that go out on the bus.
package icap_pkg;

    localparam logic [31:0] ICAP_DUMMY     = 32'hFFFF_FFFF;
    localparam logic [31:0] ICAP_SYNC      = 32'hAA99_5566;
    localparam logic [31:0] ICAP_NOOP      = 32'h2000_0000;
    localparam logic [31:0] ICAP_WR_WBSTAR = 32'h3002_0001;
    localparam logic [31:0] ICAP_WR_CMD    = 32'h3000_8001;
    localparam logic [31:0] ICAP_CMD_IPROG = 32'h0000_000F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_REQ,
        ST_GAP,
        ST_DONE
    } state_t;

    // Byte-mode ICAP expects each byte with its bit order reversed.
    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/icap_reload_seq.sv
// Wishbone master that plays the IPROG command sequence into the byte-wide
// ICAP slave, one single-byte write per bus cycle, with a gap between writes.
module icap_reload_seq
    import icap_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter bit BITSWAP     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] wbstar,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] dat_o,
    input  logic        ack_i,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t      r_state;
    logic [4:0]  r_idx;
    logic [7:0]  r_cnt;
    logic [31:0] r_wbstar;
    logic        r_stb;
    logic [7:0]  r_dat;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic [31:0] w_word;
    logic [7:0]  w_raw;
    logic [7:0]  w_byte;

    always_comb begin
        w_word = ICAP_DUMMY;
        case (r_idx[4:2])
            3'd0: w_word = ICAP_DUMMY;
            3'd1: w_word = ICAP_SYNC;
            3'd2: w_word = ICAP_NOOP;
            3'd3: w_word = ICAP_WR_WBSTAR;
            3'd4: w_word = r_wbstar;
            3'd5: w_word = ICAP_WR_CMD;
            3'd6: w_word = ICAP_CMD_IPROG;
            3'd7: w_word = ICAP_NOOP;
            default: w_word = ICAP_DUMMY;
        endcase
    end

    // Most significant byte of each word goes out first.
    always_comb begin
        w_raw = w_word[31:24];
        case (r_idx[1:0])
            2'd0: w_raw = w_word[31:24];
            2'd1: w_raw = w_word[23:16];
            2'd2: w_raw = w_word[15:8];
            2'd3: w_raw = w_word[7:0];
            default: w_raw = w_word[31:24];
        endcase
    end

    assign w_byte = (BITSWAP != 1'b0) ? bitrev8(w_raw) : w_raw;

    // LATCH spends one cycle so the first request starts on the edge after start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_wbstar <= '0;
            r_stb    <= 1'b0;
            r_dat    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_wbstar <= wbstar;
                        r_err    <= 1'b0;
                        r_idx    <= '0;
                        r_state  <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    r_cnt   <= '0;
                    r_stb   <= 1'b1;
                    r_dat   <= w_byte;
                    r_busy  <= 1'b1;
                    r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (ack_i) begin
                        r_stb <= 1'b0;
                        r_dat <= '0;
                        if (r_idx == 5'd31) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 5'd1;
                            r_state <= ST_GAP;
                        end
                    end else if (r_cnt == 8'(ACK_TIMEOUT)) begin
                        r_stb   <= 1'b0;
                        r_dat   <= '0;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    r_cnt   <= '0;
                    r_stb   <= 1'b1;
                    r_dat   <= w_byte;
                    r_state <= ST_REQ;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_stb   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cyc_o = r_stb;
    assign stb_o = r_stb;
    assign we_o  = r_stb;
    assign dat_o = {24'h0, r_dat};
    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;

endmodule

// File: tb/tb_icap_reload_seq.sv
// Directed bench for icap_reload_seq: one bit-swapping and one pass-through
// instance run side by side, each talking to a small 2-cycle-ack ICAP slave.
module tb_icap_reload_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] wbstar = '0;
    logic        ackEn = 1'b1;

    logic        cyc1, stb1, we1, ack1, busy1, done1, err1;
    logic [31:0] dat1;
    logic        cyc0, stb0, we0, ack0, busy0, done0, err0;
    logic [31:0] dat0;

    int total = 0;
    int bad = 0;

    logic [7:0] cap1 [$];
    logic [7:0] cap0 [$];
    logic [7:0] expTab [32];

    always #5 clk = ~clk;

    icap_reload_seq #(.ACK_TIMEOUT(15), .BITSWAP(1'b1)) u_sw1 (
        .clk(clk), .reset(reset), .start(start), .wbstar(wbstar),
        .cyc_o(cyc1), .stb_o(stb1), .we_o(we1), .dat_o(dat1), .ack_i(ack1),
        .busy(busy1), .done(done1), .err(err1)
    );

    icap_reload_seq #(.ACK_TIMEOUT(15), .BITSWAP(1'b0)) u_sw0 (
        .clk(clk), .reset(reset), .start(start), .wbstar(wbstar),
        .cyc_o(cyc0), .stb_o(stb0), .we_o(we0), .dat_o(dat0), .ack_i(ack0),
        .busy(busy0), .done(done0), .err(err0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rev(input logic [7:0] b);
        return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
    endfunction

    // Slave models: ack raised two cycles after strobe is first seen, held one cycle.
    int sc1 = 0;
    int sc0 = 0;
    always @(posedge clk) begin
        if (reset || !ackEn) begin
            ack1 <= 1'b0; sc1 <= 0;
        end else if (ack1) begin
            ack1 <= 1'b0; sc1 <= 0;
        end else if (stb1) begin
            if (sc1 == 1) ack1 <= 1'b1; else sc1 <= sc1 + 1;
        end
    end
    always @(posedge clk) begin
        if (reset || !ackEn) begin
            ack0 <= 1'b0; sc0 <= 0;
        end else if (ack0) begin
            ack0 <= 1'b0; sc0 <= 0;
        end else if (stb0) begin
            if (sc0 == 1) ack0 <= 1'b1; else sc0 <= sc0 + 1;
        end
    end

    always @(posedge clk) begin
        if (stb1 && ack1) cap1.push_back(dat1[7:0]);
        if (stb0 && ack0) cap0.push_back(dat0[7:0]);
    end

    // Per-cycle bus protocol checks on both instances.
    logic        pStb1 = 1'b0, pAck1 = 1'b0, pStb0 = 1'b0, pAck0 = 1'b0;
    logic [31:0] pDat1 = '0, pDat0 = '0;
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("sw1 we==stb", {31'b0, we1}, {31'b0, stb1});
            checkOutput("sw1 cyc==stb", {31'b0, cyc1}, {31'b0, stb1});
            checkOutput("sw0 we==stb", {31'b0, we0}, {31'b0, stb0});
            checkOutput("sw0 cyc==stb", {31'b0, cyc0}, {31'b0, stb0});
            checkOutput("sw0 dat upper", {8'b0, dat0[31:8]}, 32'h0);
            checkOutput("sw1 dat upper", {8'b0, dat1[31:8]}, 32'h0);
            if (pStb1 && pAck1) checkOutput("sw1 gap after write", {31'b0, stb1}, 32'h0);
            if (pStb0 && pAck0) checkOutput("sw0 gap after write", {31'b0, stb0}, 32'h0);
            if (pStb1 && !pAck1 && stb1) checkOutput("sw1 dat stable", dat1, pDat1);
            if (pStb0 && !pAck0 && stb0) checkOutput("sw0 dat stable", dat0, pDat0);
        end
        pStb1 = stb1 && !reset; pAck1 = ack1; pDat1 = dat1;
        pStb0 = stb0 && !reset; pAck0 = ack0; pDat0 = dat0;
    end

    task automatic checkIdle(input string tag);
        checkOutput({tag, " sw1 ctl"}, {26'b0, cyc1, stb1, we1, busy1, done1, err1}, 32'h0);
        checkOutput({tag, " sw1 dat"}, dat1, 32'h0);
        checkOutput({tag, " sw0 ctl"}, {26'b0, cyc0, stb0, we0, busy0, done0, err0}, 32'h0);
        checkOutput({tag, " sw0 dat"}, dat0, 32'h0);
    endtask

    task automatic applyStimulus(input logic [31:0] wb, input int cycles, input int p1, input int p2,
                                 output int doneAt, output int doneCnt, output int stbCnt, output logic errAt1);
        cap1.delete(); cap0.delete();
        doneAt = -1; doneCnt = 0; stbCnt = 0; errAt1 = 1'bx;
        @(negedge clk); wbstar = wb; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 1; n <= cycles; n++) begin
            if (n == p1 || n == p2) begin start = 1'b1; wbstar = 32'hDEAD_BEEF; end
            @(posedge clk); #1 start = 1'b0;
            if (n == 1) begin
                errAt1 = err1;
                checkOutput("busy at E1", {31'b0, busy1}, 32'h1);
            end
            if (done1) begin
                doneCnt++;
                if (doneAt < 0) doneAt = n;
            end
            if (stb1) stbCnt++;
        end
    endtask

    task automatic checkBytes(input string tag, input logic [31:0] wb);
        expTab = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hAA, 8'h99, 8'h55, 8'h66,
                   8'h20, 8'h00, 8'h00, 8'h00, 8'h30, 8'h02, 8'h00, 8'h01,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h80, 8'h01,
                   8'h00, 8'h00, 8'h00, 8'h0F, 8'h20, 8'h00, 8'h00, 8'h00};
        expTab[16] = wb[31:24]; expTab[17] = wb[23:16];
        expTab[18] = wb[15:8];  expTab[19] = wb[7:0];
        checkOutput({tag, " sw1 count"}, cap1.size(), 32);
        checkOutput({tag, " sw0 count"}, cap0.size(), 32);
        for (int k = 0; k < 32; k++) begin
            checkOutput($sformatf("%s sw1 byte%0d", tag, k),
                        {24'b0, (k < cap1.size()) ? cap1[k] : 8'hxx}, {24'b0, rev(expTab[k])});
            checkOutput($sformatf("%s sw0 byte%0d", tag, k),
                        {24'b0, (k < cap0.size()) ? cap0[k] : 8'hxx}, {24'b0, expTab[k]});
        end
    endtask

    initial begin
        int dAt, dCnt, sCnt;
        logic e1;

        $display("[TB] start");
        repeat (3) @(posedge clk);
        #1 checkIdle("in reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkIdle("after reset");

        // Normal reload into 0x00400000.
        applyStimulus(32'h0040_0000, 140, -1, -1, dAt, dCnt, sCnt, e1);
        checkOutput("run1 done at E128", dAt, 128);
        checkOutput("run1 single done", dCnt, 1);
        checkOutput("run1 err", {31'b0, err1}, 32'h0);
        checkOutput("run1 busy after", {31'b0, busy1}, 32'h0);
        checkOutput("run1 bus byte4", {24'b0, (cap1.size() > 4) ? cap1[4] : 8'hxx}, 32'h55);
        checkBytes("run1", 32'h0040_0000);

        // Start re-pulsed mid-sequence and on the final ack edge.
        applyStimulus(32'h1234_5678, 170, 10, 128, dAt, dCnt, sCnt, e1);
        checkOutput("repulse done at E128", dAt, 128);
        checkOutput("repulse single run", dCnt, 1);
        checkOutput("repulse busy after", {31'b0, busy1}, 32'h0);
        checkBytes("repulse", 32'h1234_5678);

        // Slave never acks: one 16-cycle request, then abort with sticky err.
        ackEn = 1'b0;
        applyStimulus(32'h0040_0000, 40, -1, -1, dAt, dCnt, sCnt, e1);
        checkOutput("timeout done at", dAt, 17);
        checkOutput("timeout single done", dCnt, 1);
        checkOutput("timeout stb cycles", sCnt, 16);
        checkOutput("timeout stb low", {31'b0, stb1}, 32'h0);
        checkOutput("timeout sw1 err", {31'b0, err1}, 32'h1);
        checkOutput("timeout sw0 err", {31'b0, err0}, 32'h1);
        checkOutput("timeout no writes", cap1.size(), 0);
        ackEn = 1'b1;
        repeat (3) @(posedge clk);
        #1 checkOutput("err sticky", {31'b0, err1}, 32'h1);

        // Next accepted start clears err and completes normally.
        applyStimulus(32'h00A0_0000, 140, -1, -1, dAt, dCnt, sCnt, e1);
        checkOutput("err cleared by start", {31'b0, e1}, 32'h0);
        checkOutput("rerun done at E128", dAt, 128);
        checkOutput("rerun err", {31'b0, err1}, 32'h0);
        checkBytes("rerun", 32'h00A0_0000);

        // Reset in the middle of a sequence.
        @(negedge clk); wbstar = 32'h0040_0000; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (49) @(posedge clk);
        #1 checkOutput("busy before reset", {31'b0, busy1}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1 checkIdle("mid reset");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkIdle("post reset idle");
        applyStimulus(32'h0080_0000, 140, -1, -1, dAt, dCnt, sCnt, e1);
        checkOutput("post reset done at E128", dAt, 128);
        checkBytes("post reset", 32'h0080_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
